reset_sequencer: RTL

//  Staged reset controller for the USB device. Holds NUM_STAGES downstream reset

---
 rtl/reset_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Staged reset controller. Holds NUM_STAGES downstream reset domains in reset
//   until the clock source has reported lock for LOCK_FILTER consecutive cycles.
//   It then releases the domains in order, bit 0 first, STAGE_DELAY cycles apart.
//   Lock loss re-sequences from the lock filter. A soft request holds all stages
//   for SOFT_HOLD cycles and then re-releases them without re-filtering lock.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous, active-high master reset
//   pll_locked  in   clock-source lock, synchronous to clk
//   soft_req    in   soft reset request, sampled every cycle
//   stage_rst   out  active-high reset per domain, bit 0 released first
//   ready       out  all stages released (RUN)
//   done_pulse  out  one-cycle pulse on each entry to RUN
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned LOCK_FILTER = 1024,
  parameter int unsigned STAGE_DELAY = 1000,
  parameter int unsigned SOFT_HOLD   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  soft_req,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  ready,
  output logic                  done_pulse
);

  localparam int unsigned LockW  = $clog2(LOCK_FILTER + 1);
  localparam int unsigned DelayW = $clog2(STAGE_DELAY + 1);
  localparam int unsigned HoldW  = $clog2(SOFT_HOLD + 1);
  localparam int unsigned IdxW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [1:0] StWaitLock = 2'd0;
  localparam logic [1:0] StRelease  = 2'd1;
  localparam logic [1:0] StRun      = 2'd2;
  localparam logic [1:0] StSoft     = 2'd3;

  localparam logic [LockW-1:0]  LockLast  = LockW'(LOCK_FILTER - 1);
  localparam logic [DelayW-1:0] DelayLast = DelayW'(STAGE_DELAY - 1);
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(SOFT_HOLD - 1);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NUM_STAGES - 1);

  logic [1:0]            state_q, state_d;
  logic [LockW-1:0]      lock_cnt_q, lock_cnt_d;
  logic [DelayW-1:0]     delay_cnt_q, delay_cnt_d;
  logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    delay_cnt_d = delay_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    idx_d       = idx_q;
    stage_rst_d = stage_rst_q;
    ready_d     = ready_q;
    done_d      = 1'b0;

    if (state_q == StWaitLock) begin
      // soft_req is deliberately ignored until lock has been filtered
      if (!pll_locked) begin
        lock_cnt_d = '0;
      end else if (lock_cnt_q == LockLast) begin
        state_d     = StRelease;
        lock_cnt_d  = '0;
        delay_cnt_d = '0;
        idx_d       = '0;
      end else begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
    end else if (!pll_locked) begin
      // Lock loss outranks a coincident soft request
      state_d     = StWaitLock;
      stage_rst_d = '1;
      ready_d     = 1'b0;
      lock_cnt_d  = '0;
      delay_cnt_d = '0;
      hold_cnt_d  = '0;
      idx_d       = '0;
    end else if (soft_req && (state_q != StSoft)) begin
      state_d     = StSoft;
      stage_rst_d = '1;
      ready_d     = 1'b0;
      delay_cnt_d = '0;
      hold_cnt_d  = '0;
      idx_d       = '0;
    end else if (state_q == StRelease) begin
      if (delay_cnt_q == DelayLast) begin
        delay_cnt_d        = '0;
        stage_rst_d[idx_q] = 1'b0;
        if (idx_q == IdxLast) begin
          state_d = StRun;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        delay_cnt_d = delay_cnt_q + 1'b1;
      end
    end else if (state_q == StSoft) begin
      // Hold length is fixed; further soft requests do not extend it
      if (hold_cnt_q == HoldLast) begin
        state_d     = StRelease;
        hold_cnt_d  = '0;
        delay_cnt_d = '0;
        idx_d       = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StWaitLock;
      lock_cnt_q  <= '0;
      delay_cnt_q <= '0;
      hold_cnt_q  <= '0;
      idx_q       <= '0;
      stage_rst_q <= '1;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      delay_cnt_q <= delay_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      idx_q       <= idx_d;
      stage_rst_q <= stage_rst_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  assign stage_rst  = stage_rst_q;
  assign ready      = ready_q;
  assign done_pulse = done_q;

endmodule
